// File: rtl/game_score_counter.sv
// rtl/game_score_counter.sv - three-digit BCD score counter with saturation, milestone and error pulses
module game_score_counter #(
   parameter logic [3:0] START_L = 4'h0,
   parameter logic [3:0] START_M = 4'h0,
   parameter logic [3:0] START_H = 4'h0
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       loadN,
   input  logic       enable1,
   input  logic       enable2,
   input  logic       add_valid,
   input  logic [3:0] add_points,
   output logic       add_ready,
   output logic [3:0] countL,
   output logic [3:0] countM,
   output logic [3:0] countH,
   output logic       sat,
   output logic       milestone,
   output logic       err
);

   logic [3:0] l_q, l_d;
   logic [3:0] m_q, m_d;
   logic [3:0] h_q, h_d;
   logic       sat_q, sat_d;
   logic       ms_q, ms_d;
   logic       err_q, err_d;

   logic       accept;
   logic       legal;
   logic [4:0] sum_l;
   logic [4:0] sub_l;
   logic       carry_l;
   logic [3:0] next_l;
   logic [3:0] inc_m;
   logic       carry_m;
   logic [3:0] next_m;
   logic [3:0] inc_h;
   logic       overflow;

   // Handshake: a request is only taken while counting is enabled, not saturated and not loading
   always_comb begin
      add_ready = enable1 & enable2 & ~sat_q & loadN;
      accept    = add_valid & add_ready;
      legal     = (add_points != 4'd0) && (add_points <= 4'd9);
   end

   // BCD ripple: units absorb the points, a single carry ripples through tens into hundreds
   always_comb begin
      sum_l    = {1'b0, l_q} + {1'b0, add_points};
      sub_l    = sum_l - 5'd10;
      carry_l  = (sum_l > 5'd9);
      next_l   = carry_l ? sub_l[3:0] : sum_l[3:0];
      inc_m    = m_q + {3'b000, carry_l};
      carry_m  = (inc_m == 4'd10);
      next_m   = carry_m ? 4'd0 : inc_m;
      inc_h    = h_q + {3'b000, carry_m};
      overflow = (inc_h == 4'd10);
   end

   // Next-state selection: load beats a request; pulses default low every cycle
   always_comb begin
      l_d   = l_q;
      m_d   = m_q;
      h_d   = h_q;
      sat_d = sat_q;
      ms_d  = 1'b0;
      err_d = 1'b0;
      if (!loadN) begin
         l_d   = START_L;
         m_d   = START_M;
         h_d   = START_H;
         sat_d = 1'b0;
      end else if (accept) begin
         if (!legal) begin
            err_d = 1'b1;
         end else if (overflow) begin
            l_d   = 4'd9;
            m_d   = 4'd9;
            h_d   = 4'd9;
            sat_d = 1'b1;
         end else begin
            l_d  = next_l;
            m_d  = next_m;
            h_d  = inc_h;
            ms_d = carry_m;
         end
      end
   end

   // State registers with synchronous active-high reset that ignores the START digits
   always_ff @(posedge clk) begin
      if (resetN) begin
         l_q   <= 4'd0;
         m_q   <= 4'd0;
         h_q   <= 4'd0;
         sat_q <= 1'b0;
         ms_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         l_q   <= l_d;
         m_q   <= m_d;
         h_q   <= h_d;
         sat_q <= sat_d;
         ms_q  <= ms_d;
         err_q <= err_d;
      end
   end

   assign countL    = l_q;
   assign countM    = m_q;
   assign countH    = h_q;
   assign sat       = sat_q;
   assign milestone = ms_q;
   assign err       = err_q;

endmodule

// File: doc/game_score_counter.md
GAME_SCORE_COUNTER -- requirements
Module: game_score_counter

Interface
REQ-001 The module SHALL have one clock and a reset that is synchronous and active-high.
REQ-002 Parameter START_L, default 4'h0, is the BCD units digit applied on load.
REQ-003 Parameter START_M, default 4'h0, is the BCD tens digit applied on load.
REQ-004 Parameter START_H, default 4'h0, is the BCD hundreds digit applied on load.
REQ-005 Port clk, input, 1 bit, is the system clock; all state SHALL update on its rising edge.
REQ-006 Port resetN, input, 1 bit, is the synchronous reset; it is active-high (asserted = 1) despite the N suffix.
REQ-007 Port loadN, input, 1 bit, is a synchronous active-low load of the START_* digits.
REQ-008 Ports enable1 and enable2, inputs, 1 bit each, are global count enables; counting SHALL require both to be 1.
REQ-009 Port add_valid, input, 1 bit, indicates that a points request is present.
REQ-010 Port add_points, input, 4 bits, is the BCD points value of the request; legal values are 1..9.
REQ-011 Port add_ready, output, 1 bit, indicates that the block can accept a request this cycle.
REQ-012 Ports countL, countM and countH, outputs, 4 bits each, are the registered BCD units, tens and hundreds digits of the score.
REQ-013 Port sat, output, 1 bit, is the registered flag indicating the score has saturated at 999.
REQ-014 Port milestone, output, 1 bit, is a one-cycle pulse on each hundreds increment.
REQ-015 Port err, output, 1 bit, is a one-cycle pulse on each accepted illegal request.

Function
REQ-016 The block SHALL apply events in this priority: resetN, then loadN=0, then an accepted request.
REQ-017 add_ready SHALL be combinational and equal to enable1 AND enable2 AND NOT sat AND loadN.
REQ-018 A request SHALL be accepted only in a cycle where add_valid=1 and add_ready=1; add_valid while add_ready=0 SHALL have no effect and SHALL be dropped, not queued.
REQ-019 An accepted legal request SHALL update the count registers at the next rising edge (1-cycle latency).
REQ-020 Units digit: s = countL + add_points; if s > 9, then countL <= s - 10 and carry = 1; otherwise countL <= s and carry = 0.
REQ-021 Tens digit: countM + carry; when this reaches 10, countM <= 0 and the carry SHALL propagate to the hundreds digit.
REQ-022 Hundreds digit: countH + carry; when this would reach 10, all digits SHALL load 9,9,9 and sat <= 1 (saturation, no wrap).
REQ-023 milestone SHALL pulse 1 for exactly the cycle after a request that increments countH without saturating, and SHALL be 0 otherwise.
REQ-024 An accepted request with add_points = 0 or add_points > 9 SHALL leave all digits unchanged and SHALL pulse err = 1 for one cycle.
REQ-025 The digit outputs SHALL never hold a non-BCD value (each digit stays in 0..9) while START_* are legal BCD.
REQ-026 Once sat = 1, the score SHALL hold at 999 until the next reset or load.
REQ-027 Load SHALL set countL/M/H to START_L/M/H, clear sat, and force milestone = 0 and err = 0; a request in the same cycle is ignored.
REQ-028 With enable1 = 0 or enable2 = 0, all state SHALL hold and the err and milestone pulses SHALL be 0.

Reset
REQ-029 When resetN = 1 at a rising edge, the next state SHALL be countL = countM = countH = 0, sat = 0, milestone = 0, err = 0, regardless of the START_* parameters.
REQ-030 Reset asserted in the same cycle as load or a request SHALL win; the request SHALL be lost.

Verification
REQ-031 Reset, then a request of 7, then a request of 5 -> score reads 007, then 012; milestone = 0.
REQ-032 Score 095 plus a request of 9 -> score 104, milestone = 1 for one cycle, sat = 0.
REQ-033 Score 995 plus a request of 9 -> score 999, sat = 1, add_ready = 0; a further add_valid leaves 999.
REQ-034 add_points = 4'hC accepted at score 042 -> score stays 042, err = 1 for one cycle.
REQ-035 loadN = 0 with START = 1,2,3 and add_valid = 1 in the same cycle -> score 321 (H=3, M=2, L=1), sat cleared, request ignored.
REQ-036 enable2 = 0 with add_valid = 1 for 3 cycles -> add_ready = 0, score unchanged; resetN = 1 mid-sequence -> score 000 at the next edge.
